// File: rtl/register_file_sweep.sv
// -----------------------------------------------------------------------------
// register_file_sweep
//
// Multi-port register file that initialises itself after reset. Once rst_n
// is released, the file is swept one register per clock. Register SP_IDX is
// loaded with SP_INIT and every other register is cleared. When the sweep
// finishes, ready rises and normal writes are accepted. Register 0 is
// hard-wired to read zero.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   we3       in   write enable (ignored until ready)
//   a3        in   write address
//   wd3       in   write data
//   ra        in   NUM_RD flattened read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd        out  NUM_RD flattened read data,      port k at [k*DATA_W +: DATA_W]
//   dbg_addr  in   debug tap address
//   dbg_data  out  raw array content at dbg_addr (no forwarding, no gating)
//   ready     out  sweep complete, writes accepted
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_SWEEP | writing init values to registers[idx], idx counting up
// ST_RUN   | normal operation, terminal until reset
// -----------------------------------------------------------------------------
module register_file_sweep #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 5,
    parameter int                 NUM_RD  = 2,
    parameter int                 SP_IDX  = 2,
    parameter logic [DATA_W-1:0]  SP_INIT = 32'h7fffefe4,
    parameter int                 BYPASS  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we3,
    input  logic [ADDR_W-1:0]          a3,
    input  logic [DATA_W-1:0]          wd3,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data,
    output logic                       ready
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_IDX);

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              ready_q;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              wr_run;

    // A RUN write to address 0 is dropped so register 0 stays zero.
    assign wr_run = (state == ST_RUN) && we3 && (a3 != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_SWEEP;
            idx     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    // idx stays at its last value when the sweep ends. It does not wrap.
                    if (idx == LAST_IDX) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // The array has no reset. Writes are suppressed while rst_n is low.
    // Writes resume with the sweep on the first released edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_SWEEP) begin
                regs[idx] <= (idx == SP_ADDR) ? SP_INIT : '0;
            end else if (wr_run) begin
                regs[a3] <= wd3;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        logic [DATA_W-1:0] rd_k;

        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_k = '0;
            if (ready_q && (ra_k != '0)) begin
                if ((BYPASS != 0) && wr_run && (a3 == ra_k)) begin
                    rd_k = wd3;
                end else begin
                    rd_k = regs[ra_k];
                end
            end
        end

        assign rd[k*DATA_W +: DATA_W] = rd_k;
    end

    assign dbg_data = regs[dbg_addr];
    assign ready    = ready_q;

endmodule

// File: tb/tb_register_file_sweep.sv
module tb_register_file_sweep;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [9:0]  ra;
    logic [4:0]  dbg_addr;
    logic [63:0] rd_b1, rd_b0;
    logic [31:0] dbg_b1, dbg_b0;
    logic        rdy_b1, rdy_b0;

    always #5 clk = ~clk;

    register_file_sweep #(.BYPASS(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a3(a3), .wd3(wd3), .ra(ra),
        .rd(rd_b1), .dbg_addr(dbg_addr), .dbg_data(dbg_b1), .ready(rdy_b1)
    );

    register_file_sweep #(.BYPASS(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a3(a3), .wd3(wd3), .ra(ra),
        .rd(rd_b0), .dbg_addr(dbg_addr), .dbg_data(dbg_b0), .ready(rdy_b0)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model. rel_edges counts released edges since the last reset.
    // The file is usable once 32 released edges have occurred. Released edge n
    // initialises register n-1.
    logic [31:0] mdl   [DEPTH];
    bit          known [DEPTH];
    int          rel_edges = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rel_edges = 0;
        end else if (rel_edges < DEPTH) begin
            mdl[rel_edges]   = (rel_edges == 2) ? 32'h7fffefe4 : 32'h0;
            known[rel_edges] = 1'b1;
            rel_edges++;
        end else if (we3 && a3 != 0) begin
            mdl[a3] = wd3;
        end
    end

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] addr);
        if (rel_edges < DEPTH || addr == 0) return 32'h0;
        if (byp && we3 && a3 != 0 && a3 == addr) return wd3;
        return mdl[addr];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_b1", {31'b0, rdy_b1}, {31'b0, rel_edges >= DEPTH});
            check("ready_b0", {31'b0, rdy_b0}, {31'b0, rel_edges >= DEPTH});
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rd%0d_b1", k), rd_b1[k*32 +: 32], exp_rd(1'b1, ra[k*5 +: 5]));
                check($sformatf("rd%0d_b0", k), rd_b0[k*32 +: 32], exp_rd(1'b0, ra[k*5 +: 5]));
            end
            if (known[dbg_addr]) begin
                check("dbg_b1", dbg_b1, mdl[dbg_addr]);
                check("dbg_b0", dbg_b0, mdl[dbg_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts released edges until ready, bounded so a stuck DUT cannot hang the bench.
    task automatic count_to_ready(output int n);
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (rdy_b1 && rdy_b0) break;
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0; ra = '0; dbg_addr = '0;
        step();
        step();
        chk_en = 1'b1;
        check("reset_ready", {31'b0, rdy_b1}, 32'h0);

        // A write attempted during the sweep must be ignored.
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'h1;
        rst_n = 1'b1;
        count_to_ready(n);
        check("sweep_edges", n, 32'd32);
        we3 = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = 5'(i);
            step();
            check($sformatf("init_reg%0d", i), dbg_b1, (i == 2) ? 32'h7fffefe4 : 32'h0);
        end
        ra[4:0] = 5'd3;
        #1;
        check("sweep_write_ignored", rd_b1[31:0], 32'h0);

        // Write then read back on the next cycle.
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
        step();
        we3 = 1'b0; ra[4:0] = 5'd5;
        #1;
        check("wr5_rd_b1", rd_b1[31:0], 32'hDEADBEEF);
        check("wr5_rd_b0", rd_b0[31:0], 32'hDEADBEEF);

        // Register 0 is immune to writes, with and without bypass.
        step();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'h12345678; ra = '0; dbg_addr = 5'd0;
        #1;
        check("r0_same_b1", rd_b1[31:0], 32'h0);
        check("r0_same_b0", rd_b0[31:0], 32'h0);
        step();
        we3 = 1'b0;
        #1;
        check("r0_after_b1", rd_b1[31:0], 32'h0);
        check("r0_after_b0", rd_b0[31:0], 32'h0);
        check("r0_dbg", dbg_b1, 32'h0);

        // A same-cycle collision forwards only when bypass is enabled.
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h11111111;
        step();
        a3 = 5'd7; wd3 = 32'hA5A5A5A5; ra = {5'd7, 5'd7}; dbg_addr = 5'd7;
        #1;
        check("byp_p0_b1", rd_b1[31:0],  32'hA5A5A5A5);
        check("byp_p1_b1", rd_b1[63:32], 32'hA5A5A5A5);
        check("nobyp_p0_b0", rd_b0[31:0], 32'h11111111);
        check("nobyp_p1_b0", rd_b0[63:32], 32'h11111111);
        check("byp_dbg_old", dbg_b1, 32'h11111111);
        step();
        we3 = 1'b0;
        #1;
        check("nobyp_after_b0", rd_b0[31:0], 32'hA5A5A5A5);

        // A reset in the middle of the sweep restarts it and clears RUN writes.
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'hCAFEF00D;
        step();
        we3 = 1'b0; ra[4:0] = 5'd9;
        #1;
        check("reg9_written", rd_b1[31:0], 32'hCAFEF00D);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        check("midsweep_ready", {31'b0, rdy_b1}, 32'h0);
        rst_n = 1'b1;
        count_to_ready(n);
        check("resweep_edges", n, 32'd32);
        ra[4:0] = 5'd9; dbg_addr = 5'd9;
        #1;
        check("reg9_cleared_rd", rd_b1[31:0], 32'h0);
        check("reg9_cleared_dbg", dbg_b0, 32'h0);

        // Random traffic with rare resets, checked every cycle by the compare process.
        for (int c = 0; c < 800; c++) begin
            step();
            rst_n    = ($urandom_range(0, 99) != 0);
            we3      = $urandom_range(0, 1);
            a3       = 5'($urandom);
            wd3      = $urandom;
            ra       = 10'($urandom);
            dbg_addr = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ra[4:0]  = a3;
            if ($urandom_range(0, 3) == 0) ra[9:5]  = a3;
        end
        step();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
